// File: rtl/framing_pkg.sv
// rtl/framing_pkg.sv - shared framing constants, framer state encoding and special-byte helper
package framing_pkg;

    localparam logic [7:0] DEFAULT_ESCAPE_BYTE = 8'h7F;
    localparam logic [7:0] DEFAULT_START_BYTE  = 8'h7D;
    localparam logic [7:0] DEFAULT_STOP_BYTE   = 8'h7E;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DATA     = 3'd1,
        ESC      = 3'd2,
        CSUM     = 3'd3,
        CSUM_ESC = 3'd4,
        STOP     = 3'd5
    } framer_state_t;

    function automatic logic is_special(input logic [7:0] b,
                                        input logic [7:0] esc,
                                        input logic [7:0] start,
                                        input logic [7:0] stop);
        return (b == esc) || (b == start) || (b == stop);
    endfunction

endpackage

// File: rtl/framer_if.sv
// rtl/framer_if.sv - byte stream bundle with master/slave views
interface framer_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/framer.sv
// rtl/framer.sv - wraps byte packets as START, escaped payload, STOP; FRAMER_CHECKSUM_EN adds a trailing checksum
module framer
    import framing_pkg::*;
#(
    parameter logic [7:0] ESCAPE_BYTE = DEFAULT_ESCAPE_BYTE,
    parameter logic [7:0] START_BYTE  = DEFAULT_START_BYTE,
    parameter logic [7:0] STOP_BYTE   = DEFAULT_STOP_BYTE
) (
    input  logic     aclk,
    input  logic     areset,
    framer_if.slave  target,
    framer_if.master initiator
);

`ifdef FRAMER_CHECKSUM_EN
    localparam framer_state_t TAIL_STATE = CSUM;
`else
    localparam framer_state_t TAIL_STATE = STOP;
`endif

    framer_state_t state_q, state_d;
    logic          valid_q, last_q;
    logic [7:0]    data_q;
    logic [7:0]    hold_data_q;
    logic          hold_last_q;
    logic          adv, in_hs, in_special;
    logic          load, load_last, hold_capture;
    logic [7:0]    load_data;

    assign adv        = !valid_q || initiator.tready;
    assign in_hs      = adv && (state_q == DATA) && target.tvalid;
    assign in_special = is_special(target.tdata, ESCAPE_BYTE, START_BYTE, STOP_BYTE);

    assign target.tready    = adv && (state_q == DATA);
    assign initiator.tvalid = valid_q;
    assign initiator.tdata  = data_q;
    assign initiator.tlast  = last_q;

`ifdef FRAMER_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       csum_special;

    assign csum_special = is_special(csum_q, ESCAPE_BYTE, START_BYTE, STOP_BYTE);

    // Sum of unescaped payload bytes; cleared when the START beat is loaded.
    always_ff @(posedge aclk) begin
        if (areset) begin
            csum_q <= 8'h00;
        end else if (state_q == IDLE && adv && target.tvalid) begin
            csum_q <= 8'h00;
        end else if (in_hs) begin
            csum_q <= csum_q + target.tdata;
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (adv && target.tvalid) state_d = DATA;
            DATA: if (in_hs) begin
                if (in_special)         state_d = ESC;
                else if (target.tlast)  state_d = TAIL_STATE;
            end
            ESC:  if (adv) state_d = hold_last_q ? TAIL_STATE : DATA;
`ifdef FRAMER_CHECKSUM_EN
            CSUM:     if (adv) state_d = csum_special ? CSUM_ESC : STOP;
            CSUM_ESC: if (adv) state_d = STOP;
`endif
            STOP: if (adv) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load         = 1'b0;
        load_data    = 8'h00;
        load_last    = 1'b0;
        hold_capture = 1'b0;
        case (state_q)
            IDLE: if (adv && target.tvalid) begin
                load      = 1'b1;
                load_data = START_BYTE;
            end
            DATA: if (in_hs) begin
                load         = 1'b1;
                hold_capture = in_special;
                load_data    = in_special ? ESCAPE_BYTE : target.tdata;
            end
            ESC: if (adv) begin
                load      = 1'b1;
                load_data = hold_data_q;
            end
`ifdef FRAMER_CHECKSUM_EN
            CSUM: if (adv) begin
                load      = 1'b1;
                load_data = csum_special ? ESCAPE_BYTE : csum_q;
            end
            CSUM_ESC: if (adv) begin
                load      = 1'b1;
                load_data = csum_q;
            end
`endif
            STOP: if (adv) begin
                load      = 1'b1;
                load_data = STOP_BYTE;
                load_last = 1'b1;
            end
            default: ;
        endcase
    end

    // Output register: data/last hold while stalled, valid drops when nothing is loaded.
    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
        end else if (adv) begin
            valid_q <= load;
            if (load) begin
                data_q <= load_data;
                last_q <= load_last;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            hold_data_q <= 8'h00;
            hold_last_q <= 1'b0;
        end else if (hold_capture) begin
            hold_data_q <= target.tdata;
            hold_last_q <= target.tlast;
        end
    end

endmodule

// File: tb/tb_framer.sv
// tb/tb_framer.sv - randomized self-checking bench for framer against a packet-level framing model
module tb_framer;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    framer_if tgt ();
    framer_if ini ();

    framer dut (
        .aclk      (aclk),
        .areset    (areset),
        .target    (tgt),
        .initiator (ini)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [8:0] in_q[$];
    logic [8:0] exp_q[$];
    int         beat_cyc[$];
    int         in_cyc[$];
    logic       tv_hold = 1'b0;
    logic       rand_rdy = 1'b0;
    logic       rand_gap = 1'b0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat = 9'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pk(input logic [7:0] d, input logic l = 1'b0);
        in_q.push_back({l, d});
    endtask

    task automatic ex(input logic [7:0] d, input logic l = 1'b0);
        exp_q.push_back({l, d});
    endtask

    task automatic ex_esc(input logic [7:0] d);
        if (d == 8'h7F || d == 8'h7D || d == 8'h7E) ex(8'h7F);
        ex(d);
    endtask

    task automatic model_pkt(input logic [7:0] pkt[$]);
        int sum = 0;
        ex(8'h7D);
        foreach (pkt[i]) begin
            sum = (sum + int'(pkt[i])) % 256;
            ex_esc(pkt[i]);
        end
`ifdef FRAMER_CHECKSUM_EN
        ex_esc(sum[7:0]);
`endif
        ex(8'h7E, 1'b1);
    endtask

    task automatic clr();
        beat_cyc.delete();
        in_cyc.delete();
    endtask

    task automatic step();
        @(negedge aclk);
        cyc++;
        if (!tv_hold && in_q.size() > 0 && (!rand_gap || $urandom_range(0, 2) != 0)) tv_hold = 1'b1;
        tgt.tvalid = tv_hold;
        if (tv_hold) {tgt.tlast, tgt.tdata} = in_q[0];
        ini.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (tgt.tvalid && tgt.tready) begin
            void'(in_q.pop_front());
            tv_hold = 1'b0;
            in_cyc.push_back(cyc);
        end
        if (prev_stall) begin
            check("stall_valid", 32'(ini.tvalid), 32'd1);
            check("stall_beat", 32'({ini.tlast, ini.tdata}), 32'(prev_beat));
        end
        if (ini.tvalid && ini.tready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("beat", 32'({ini.tlast, ini.tdata}), 32'(exp_q.pop_front()));
            beat_cyc.push_back(cyc);
        end
        prev_stall = ini.tvalid && !ini.tready;
        prev_beat  = {ini.tlast, ini.tdata};
    endtask

    task automatic run(input int budget);
        for (int i = 0; i < budget && (in_q.size() != 0 || exp_q.size() != 0); i++) step();
        check("drain", 32'(in_q.size() + exp_q.size()), 32'd0);
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        step();
        step();
    endtask

    task automatic check_consec(input string tag);
        if (beat_cyc.size() > 0)
            check(tag, 32'(beat_cyc[beat_cyc.size()-1] - beat_cyc[0]), 32'(beat_cyc.size() - 1));
        else
            check(tag, 32'(beat_cyc.size()), 32'd1);
    endtask

    initial begin
        logic [7:0] pkt[$];
        tgt.tvalid = 1'b0;
        tgt.tdata  = 8'h00;
        tgt.tlast  = 1'b0;
        ini.tready = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        #1;
        check("rst_valid", 32'(ini.tvalid), 32'd0);
        check("rst_last", 32'(ini.tlast), 32'd0);
        check("rst_data", 32'(ini.tdata), 32'd0);
        check("rst_tready", 32'(tgt.tready), 32'd0);

        // 1: plain packet, full rate after START, 1-cycle latency
        clr();
        pk(8'h01); pk(8'h02); pk(8'h03, 1'b1);
        ex(8'h7D); ex(8'h01); ex(8'h02); ex(8'h03);
`ifdef FRAMER_CHECKSUM_EN
        ex(8'h06);
`endif
        ex(8'h7E, 1'b1);
        run(100);
        check_consec("t1_consec");
        if (beat_cyc.size() > 1 && in_cyc.size() > 0)
            check("t1_latency", 32'(beat_cyc[1] - in_cyc[0]), 32'd1);
        else
            check("t1_latency_beats", 32'(beat_cyc.size()), 32'd5);

        // 2: every payload byte special
        clr();
        pk(8'h7F); pk(8'h7D); pk(8'h7E, 1'b1);
        ex(8'h7D); ex(8'h7F); ex(8'h7F); ex(8'h7F); ex(8'h7D); ex(8'h7F); ex(8'h7E);
`ifdef FRAMER_CHECKSUM_EN
        ex(8'h7A);
`endif
        ex(8'h7E, 1'b1);
        run(100);

        // 4: back-to-back single-byte packets
        clr();
        pk(8'hAA, 1'b1); pk(8'hBB, 1'b1);
        ex(8'h7D); ex(8'hAA);
`ifdef FRAMER_CHECKSUM_EN
        ex(8'hAA);
`endif
        ex(8'h7E, 1'b1);
        ex(8'h7D); ex(8'hBB);
`ifdef FRAMER_CHECKSUM_EN
        ex(8'hBB);
`endif
        ex(8'h7E, 1'b1);
        run(100);
        check_consec("t4_consec");

`ifdef FRAMER_CHECKSUM_EN
        // 5: checksum, plain and special
        clr();
        pk(8'h01); pk(8'h02, 1'b1);
        ex(8'h7D); ex(8'h01); ex(8'h02); ex(8'h03); ex(8'h7E, 1'b1);
        pk(8'h7D); pk(8'h01, 1'b1);
        ex(8'h7D); ex(8'h7F); ex(8'h7D); ex(8'h01); ex(8'h7F); ex(8'h7E); ex(8'h7E, 1'b1);
        run(100);
`endif

        // 3: random packets, random stalls and source gaps, checked against the model
        for (int p = 0; p < 16; p++) begin
            int len;
            len = (p == 0) ? 64 : int'($urandom_range(1, 64));
            pkt.delete();
            for (int i = 0; i < len; i++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'h7D, 8'h7F)) : 8'($urandom);
                pkt.push_back(b);
                pk(b, i == len - 1);
            end
            model_pkt(pkt);
        end
        clr();
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        run(20000);

        // 6: reset mid-frame discards the partial frame and restarts the checksum
        clr();
        pk(8'h11); pk(8'h22);
        ex(8'h7D); ex(8'h11); ex(8'h22);
        run(100);
        @(negedge aclk);
        areset = 1'b1;
        tgt.tvalid = 1'b0;
        tv_hold = 1'b0;
        prev_stall = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(ini.tvalid), 32'd0);
        step();
        check("t6_post_valid", 32'(ini.tvalid), 32'd0);
        pk(8'h33, 1'b1);
        ex(8'h7D); ex(8'h33);
`ifdef FRAMER_CHECKSUM_EN
        ex(8'h33);
`endif
        ex(8'h7E, 1'b1);
        run(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
